// File: rtl/machine_jk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : machine_jk_pkg
// Description : Shared constants for the machine_jk zero-run detector.
//               STATE_W         - state vector width (3 bits)
//               ST_A .. ST_E    - legal state codes (000..100)
// Revision    : 1.0 - initial release
// ============================================================================
package machine_jk_pkg;

  localparam int STATE_W = 3;

  // Each legal state records how many consecutive zeros have been seen.
  // ST_E is the saturating "four or more" state.
  localparam logic [STATE_W-1:0] ST_A = 3'b000;
  localparam logic [STATE_W-1:0] ST_B = 3'b001;
  localparam logic [STATE_W-1:0] ST_C = 3'b010;
  localparam logic [STATE_W-1:0] ST_D = 3'b011;
  localparam logic [STATE_W-1:0] ST_E = 3'b100;

endpackage : machine_jk_pkg
`default_nettype wire

// File: rtl/machine_jk_jk_ff.sv
`default_nettype none
// ============================================================================
// Module      : jk_ff
// Description : Single JK flip-flop with synchronous active-low reset.
//               JK = 00 hold, 01 clear, 10 set, 11 toggle.
// Ports       : CLK   - rising-edge clock
//               RESET - synchronous active-low reset, forces Q = 0
//               J, K  - excitation inputs
//               Q     - flip-flop output
// Revision    : 1.0 - initial release
// ============================================================================
module jk_ff (
  input  logic CLK,
  input  logic RESET,
  input  logic J,
  input  logic K,
  output logic Q
);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      Q <= 1'b0;
    end else begin
      case ({J, K})
        2'b00:   Q <= Q;
        2'b01:   Q <= 1'b0;
        2'b10:   Q <= 1'b1;
        default: Q <= ~Q;
      endcase
    end
  end

endmodule : jk_ff
`default_nettype wire

// File: rtl/machine_jk.sv
`default_nettype none
// ============================================================================
// Module      : machine_jk
// Description : Moore detector that raises F after four or more consecutive
//               x = 0 samples. State is held in three JK flip-flops; the top
//               level only forms the J/K excitation and decodes F.
// Ports       : CLK   - rising-edge clock
//               RESET - synchronous active-low reset, forces S = 000
//               x     - serial data input
//               F     - detect flag, high only in state E (100)
//               S     - current state, S[2] is the MSB
// Revision    : 1.0 - initial release
// ============================================================================
module machine_jk
  import machine_jk_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic               x,
  output logic               F,
  output logic [STATE_W-1:0] S
);

  logic               xn;
  logic [STATE_W-1:0] j;
  logic [STATE_W-1:0] k;
  logic [STATE_W-1:0] q;

  assign xn = ~x;

  // Bit 0 sets on a zero unless already in E; K0 tied high so it never
  // survives two edges, which yields the alternating LSB of the count.
  assign j[0] = xn & ~q[2];
  assign k[0] = 1'b1;

  // Bit 1 sets when leaving B; clears on any one, from D, or from any
  // code with S2 set (covers the illegal 110/111 recovery).
  assign j[1] = xn & ~q[2] & q[0];
  assign k[1] = x | q[0] | q[2];

  // Bit 2 sets when leaving D; holds in E only while x = 0 and the lower
  // bits are clear, so the illegal codes 101/110/111 all fall back to A.
  assign j[2] = xn & q[1] & q[0];
  assign k[2] = x | q[1] | q[0];

  jk_ff u_ff0 (.CLK(CLK), .RESET(RESET), .J(j[0]), .K(k[0]), .Q(q[0]));
  jk_ff u_ff1 (.CLK(CLK), .RESET(RESET), .J(j[1]), .K(k[1]), .Q(q[1]));
  jk_ff u_ff2 (.CLK(CLK), .RESET(RESET), .J(j[2]), .K(k[2]), .Q(q[2]));

  assign S = q;
  assign F = q[2] & ~q[1] & ~q[0];

endmodule : machine_jk
`default_nettype wire

// File: tb/tb_machine_jk.sv
`default_nettype none
// ============================================================================
// Module      : tb_machine_jk
// Description : Directed self-checking bench for machine_jk and jk_ff.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_machine_jk;

  logic       CLK;
  logic       RESET;
  logic       x;
  logic       F;
  logic [2:0] S;

  logic       cell_rst;
  logic       cell_j;
  logic       cell_k;
  logic       cell_q;

  int n_checks;
  int n_fails;

  machine_jk dut (
    .CLK   (CLK),
    .RESET (RESET),
    .x     (x),
    .F     (F),
    .S     (S)
  );

  jk_ff u_cell (
    .CLK   (CLK),
    .RESET (cell_rst),
    .J     (cell_j),
    .K     (cell_k),
    .Q     (cell_q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one edge worth of inputs, then check state and flag after it.
  task automatic step(input logic rst_v, input logic x_v,
                      input logic [2:0] exp_s, input logic exp_f,
                      input string tag);
    @(negedge CLK);
    RESET = rst_v;
    x     = x_v;
    @(posedge CLK);
    #1;
    check_eq({tag, "_S"}, {29'd0, S}, {29'd0, exp_s});
    check_eq({tag, "_F"}, {31'd0, F}, {31'd0, exp_f});
  endtask

  task automatic illegal(input logic [2:0] code, input logic x_v,
                         input string tag);
    @(negedge CLK);
    dut.u_ff0.Q = code[0];
    dut.u_ff1.Q = code[1];
    dut.u_ff2.Q = code[2];
    RESET = 1'b1;
    x     = x_v;
    #1;
    check_eq({tag, "_forced"}, {29'd0, S}, {29'd0, code});
    check_eq({tag, "_forcedF"}, {31'd0, F}, 32'd0);
    @(posedge CLK);
    #1;
    check_eq({tag, "_rec"}, {29'd0, S}, 32'd0);
  endtask

  task automatic cell_step(input logic r, input logic jv, input logic kv,
                           input logic exp_q, input string tag);
    @(negedge CLK);
    cell_rst = r;
    cell_j   = jv;
    cell_k   = kv;
    @(posedge CLK);
    #1;
    check_eq(tag, {31'd0, cell_q}, {31'd0, exp_q});
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    RESET    = 1'b0;
    x        = 1'b0;
    cell_rst = 1'b0;
    cell_j   = 1'b0;
    cell_k   = 1'b0;

    // Reset with x = 0 held low: must stay in A, not advance to B.
    step(1'b0, 1'b0, 3'b000, 1'b0, "rst1");
    step(1'b0, 1'b0, 3'b000, 1'b0, "rst2");

    // Count-up with saturation in E.
    step(1'b1, 1'b0, 3'b001, 1'b0, "cnt1");
    step(1'b1, 1'b0, 3'b010, 1'b0, "cnt2");
    step(1'b1, 1'b0, 3'b011, 1'b0, "cnt3");
    step(1'b1, 1'b0, 3'b100, 1'b1, "cnt4");
    step(1'b1, 1'b0, 3'b100, 1'b1, "cnt5");

    // x = 1 from E drops F immediately.
    step(1'b1, 1'b1, 3'b000, 1'b0, "brkE");

    // Reach D, break with x = 1, then count again to E.
    step(1'b1, 1'b0, 3'b001, 1'b0, "d1");
    step(1'b1, 1'b0, 3'b010, 1'b0, "d2");
    step(1'b1, 1'b0, 3'b011, 1'b0, "d3");
    step(1'b1, 1'b1, 3'b000, 1'b0, "brkD");
    step(1'b1, 1'b0, 3'b001, 1'b0, "re1");
    step(1'b1, 1'b0, 3'b010, 1'b0, "re2");
    step(1'b1, 1'b0, 3'b011, 1'b0, "re3");
    step(1'b1, 1'b0, 3'b100, 1'b1, "re4");

    // x = 1 from B and C also return to A.
    step(1'b1, 1'b0, 3'b100, 1'b1, "hold");
    step(1'b1, 1'b1, 3'b000, 1'b0, "toA");
    step(1'b1, 1'b0, 3'b001, 1'b0, "b1");
    step(1'b1, 1'b1, 3'b000, 1'b0, "brkB");
    step(1'b1, 1'b0, 3'b001, 1'b0, "c1");
    step(1'b1, 1'b0, 3'b010, 1'b0, "c2");
    step(1'b1, 1'b1, 3'b000, 1'b0, "brkC");

    // Reset mid-detect, then counting restarts from zero.
    step(1'b1, 1'b0, 3'b001, 1'b0, "m1");
    step(1'b1, 1'b0, 3'b010, 1'b0, "m2");
    step(1'b1, 1'b0, 3'b011, 1'b0, "m3");
    step(1'b1, 1'b0, 3'b100, 1'b1, "m4");
    step(1'b0, 1'b0, 3'b000, 1'b0, "mrst");
    step(1'b1, 1'b0, 3'b001, 1'b0, "mrel");
    step(1'b1, 1'b0, 3'b010, 1'b0, "mrel2");

    // Illegal codes recover to A in one edge regardless of x.
    illegal(3'b101, 1'b0, "ill101x0");
    illegal(3'b110, 1'b0, "ill110x0");
    illegal(3'b111, 1'b0, "ill111x0");
    illegal(3'b101, 1'b1, "ill101x1");
    illegal(3'b110, 1'b1, "ill110x1");
    illegal(3'b111, 1'b1, "ill111x1");

    // Standalone JK cell truth table.
    cell_step(1'b0, 1'b0, 1'b0, 1'b0, "jk_rst");
    cell_step(1'b1, 1'b0, 1'b0, 1'b0, "jk_q0_00");
    cell_step(1'b1, 1'b0, 1'b1, 1'b0, "jk_q0_01");
    cell_step(1'b1, 1'b1, 1'b0, 1'b1, "jk_q0_10");
    cell_step(1'b1, 1'b0, 1'b0, 1'b1, "jk_q1_00");
    cell_step(1'b1, 1'b1, 1'b0, 1'b1, "jk_q1_10");
    cell_step(1'b1, 1'b1, 1'b1, 1'b0, "jk_q1_11");
    cell_step(1'b1, 1'b1, 1'b1, 1'b1, "jk_q0_11");
    cell_step(1'b1, 1'b0, 1'b1, 1'b0, "jk_q1_01");
    cell_step(1'b1, 1'b1, 1'b0, 1'b1, "jk_set");
    cell_step(1'b0, 1'b1, 1'b0, 1'b0, "jk_rst_ovr");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule : tb_machine_jk
`default_nettype wire
